timer_counter: RTL and testbench



---
 rtl/timer_pkg.sv | 37 +++
 rtl/timer_counter.sv | 121 ++++++++++++
 tb/tb_timer_counter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared constants and types for the memory-mapped timer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int EN      = 0;
    localparam int MODE_LO = 1;
    localparam int MODE_HI = 2;
    localparam int IM      = 3;
    localparam int CTRL_W  = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Only the reload code reloads; the two undefined codes behave as one-shot.
    function automatic logic is_reload(input logic [1:0] mode);
        return (mode == MODE_RELOAD);
    endfunction

endpackage : timer_pkg

`default_nettype wire

// File: rtl/timer_counter.sv
// ============================================================================
//  Module      : timer_counter
//  Description : Programmable 32-bit down-counter with interrupt, bus slave.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_counter
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  Addr,
    input  logic        We,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        IRQ
);

    state_e              state_q, state_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [31:0]         preset_q, preset_d;
    logic [31:0]         count_q, count_d;
    logic                irq_pend_q, irq_pend_d;

    logic                w_wr_ctrl;
    logic                w_wr_preset;
    logic                w_enable;
    logic                w_reload;

    assign w_wr_ctrl   = We && (Addr == ADDR_CTRL);
    assign w_wr_preset = We && (Addr == ADDR_PRESET);
    assign w_enable    = ctrl_q[EN];
    assign w_reload    = is_reload(ctrl_q[MODE_HI:MODE_LO]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_pend_d = irq_pend_q;

        case (state_q)
            IDLE: begin
                if (w_enable) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                // Expiring at 1 or 0 makes a preset of 0 behave like 1 and stops wrap-around.
                if (!w_enable) begin
                    state_d = IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = '0;
                    irq_pend_d = 1'b1;
                    state_d    = INT;
                end
            end
            INT: begin
                if (w_reload) begin
                    count_d    = preset_q;
                    irq_pend_d = 1'b0;
                    state_d    = w_enable ? CNT : IDLE;
                end else begin
                    ctrl_d[EN] = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_wr_preset) begin
            preset_d = DataIn;
        end

        // A CPU write to CTRL overrides the hardware Enable clear and acknowledges the interrupt.
        if (w_wr_ctrl) begin
            ctrl_d     = DataIn[CTRL_W-1:0];
            irq_pend_d = 1'b0;
        end
    end

    always_comb begin
        DataOut = '0;
        case (Addr)
            ADDR_CTRL:   DataOut = {{(32-CTRL_W){1'b0}}, ctrl_q};
            ADDR_PRESET: DataOut = preset_q;
            ADDR_COUNT:  DataOut = count_q;
            default:     DataOut = '0;
        endcase
    end

    assign IRQ = irq_pend_q & ctrl_q[IM];

endmodule : timer_counter

`default_nettype wire

// File: tb/tb_timer_counter.sv
// ============================================================================
//  Module      : tb_timer_counter
//  Description : Self-checking bench for timer_counter with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  Addr = 2'd0;
    logic        We = 1'b0;
    logic [31:0] DataIn = 32'd0;
    logic [31:0] DataOut;
    logic        IRQ;

    timer_counter dut (
        .clk     (clk),
        .rst     (rst),
        .Addr    (Addr),
        .We      (We),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .IRQ     (IRQ)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: timer activity as a phase number plus architectural registers.
    typedef struct {
        int          phase;   // 0 stopped, 1 arming, 2 counting down, 3 just expired
        logic [3:0]  ctrl;
        logic [31:0] preset;
        logic [31:0] count;
        bit          pend;
    } mdl_t;

    mdl_t m;
    bit   m_valid = 1'b0;

    function automatic mdl_t model_next(input mdl_t s, input logic r, input logic [1:0] a,
                                        input logic w, input logic [31:0] d);
        mdl_t n = s;
        bit on   = s.ctrl[0];
        bit auto = (s.ctrl[2:1] == 2'b01);
        if (r) begin
            n.phase = 0; n.ctrl = 4'h0; n.preset = 32'd0; n.count = 32'd0; n.pend = 1'b0;
            return n;
        end
        if (s.phase == 0 && on) begin
            n.phase = 1;
        end else if (s.phase == 1) begin
            n.count = s.preset;
            n.phase = 2;
        end else if (s.phase == 2) begin
            if (!on)                 n.phase = 0;
            else if (s.count >= 2)   n.count = s.count - 1;
            else begin
                n.count = 32'd0; n.pend = 1'b1; n.phase = 3;
            end
        end else if (s.phase == 3) begin
            if (auto) begin
                n.count = s.preset; n.pend = 1'b0; n.phase = on ? 2 : 0;
            end else begin
                n.ctrl[0] = 1'b0; n.phase = 0;
            end
        end
        if (w && a == 2'd1) n.preset = d;
        if (w && a == 2'd0) begin
            n.ctrl = d[3:0];
            n.pend = 1'b0;
        end
        return n;
    endfunction

    function automatic logic [31:0] model_read(input mdl_t s, input logic [1:0] a);
        if (a == 2'd0) return {28'd0, s.ctrl};
        if (a == 2'd1) return s.preset;
        if (a == 2'd2) return s.count;
        return 32'd0;
    endfunction

    always @(posedge clk) begin
        m       <= model_next(m, rst, Addr, We, DataIn);
        m_valid <= m_valid | rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model DataOut", DataOut, model_read(m, Addr));
            check("model IRQ", {31'd0, IRQ}, {31'd0, m.pend & m.ctrl[3]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a; We = 1'b1; DataIn = d;
        tick();
        We = 1'b0; DataIn = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        Addr = a;
        #2;
        check(name, DataOut, exp);
    endtask

    task automatic chk_irq(input logic exp, input string name);
        check(name, {31'd0, IRQ}, {31'd0, exp});
    endtask

    initial begin
        // Reset with registers preloaded and the counter running
        repeat (2) tick();
        rst = 1'b0;
        wr(2'd1, 32'h0000_1234);
        wr(2'd0, 32'h0000_000B);
        repeat (4) tick();
        rd(2'd1, 32'h0000_1234, "preload preset");
        rd(2'd0, 32'h0000_000B, "preload ctrl");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int a = 0; a < 4; a++) rd(a[1:0], 32'd0, $sformatf("reset read addr%0d", a));
        chk_irq(1'b0, "reset irq");

        // One-shot, PRESET=5: IRQ rises after E7
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k >= 2) rd(2'd2, (k < 7) ? 32'(7 - k) : 32'd0, $sformatf("oneshot count E%0d", k));
            chk_irq(k >= 7, $sformatf("oneshot irq E%0d", k));
        end
        tick();
        rd(2'd0, 32'h8, "oneshot ctrl after expiry");
        rd(2'd2, 32'd0, "oneshot count after expiry");
        chk_irq(1'b1, "oneshot irq held");
        wr(2'd0, 32'h0);
        chk_irq(1'b0, "oneshot irq cleared by write");

        // Auto-reload, PRESET=3: pulses after E5, E9, E13
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 13; k++) begin
            tick();
            chk_irq(k == 5 || k == 9 || k == 13, $sformatf("reload irq E%0d", k));
            if (k >= 2) rd(2'd2, 32'(3 - ((k - 2) % 4)), $sformatf("reload count E%0d", k));
        end
        wr(2'd0, 32'h0);
        repeat (2) tick();
        chk_irq(1'b0, "reload stopped irq");

        // Masked interrupt, PRESET=2
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk_irq(1'b0, $sformatf("masked irq E%0d", k));
        end
        rd(2'd0, 32'h0, "masked ctrl after expiry");
        wr(2'd0, 32'h0);
        wr(2'd0, 32'h8);
        tick();
        chk_irq(1'b0, "unmask after clearing write");
        rd(2'd0, 32'h8, "unmask ctrl");
        wr(2'd0, 32'h0);

        // Pause, ignored COUNT write, restart through LOAD
        wr(2'd1, 32'd100);
        wr(2'd0, 32'h1);
        repeat (5) tick();
        rd(2'd2, 32'd97, "pause count before");
        wr(2'd0, 32'h0);
        repeat (3) tick();
        rd(2'd2, 32'd96, "pause count frozen");
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, 32'd96, "count write ignored");
        wr(2'd1, 32'd10);
        rd(2'd1, 32'd10, "new preset");
        wr(2'd0, 32'h1);
        repeat (2) tick();
        rd(2'd2, 32'd10, "restart loads preset");
        tick();
        rd(2'd2, 32'd9, "restart decrements");
        wr(2'd0, 32'h0);
        repeat (2) tick();

        // PRESET=0 expires after E3; CTRL write in INT wins; reset in INT
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        repeat (2) tick();
        chk_irq(1'b0, "preset0 irq E2");
        tick();
        chk_irq(1'b1, "preset0 irq E3");
        wr(2'd0, 32'h9);
        rd(2'd0, 32'h9, "int-cycle write ctrl wins");
        chk_irq(1'b0, "int-cycle write clears pend");
        repeat (3) tick();
        chk_irq(1'b1, "rearmed irq");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_irq(1'b0, "reset in INT irq");
        for (int a = 0; a < 4; a++) rd(a[1:0], 32'd0, $sformatf("reset in INT addr%0d", a));
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_timer_counter

`default_nettype wire
